spi_master_param: RTL and testbench

Parametrised full-duplex SPI master, successor to the fixed-format `master` block. Each transfer loads a WIDTH-bit word and shifts it out on mosi while capturing miso. Features include a configurable sclk divider, all four CPOL/CPHA modes selected per transfer, a selectable bit order, and one of NUM_SS active-low slave selects. The block sits between the local control logic (start/busy/done handshake) and the off-chip SPI pins.

---
 rtl/spi_master_param_if.sv | 27 ++
 rtl/spi_master_param.sv | 166 ++++++++++++++++
 tb/tb_spi_master_param.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_master_param_if.sv
// Control-side handshake bundle for spi_master_param: start request with the
// per-transfer settings, and busy/done/rx_data status back to the requester.
interface spi_master_param_if #(
    parameter int WIDTH = 8,
    parameter int SEL_W = 1
);
    logic             start;
    logic [WIDTH-1:0] tx_data;
    logic [SEL_W-1:0] ss_sel;
    logic             cpol;
    logic             cpha;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] rx_data;

    // Requester side: issues transfers and observes completion.
    modport master (
        output start, tx_data, ss_sel, cpol, cpha,
        input  busy, done, rx_data
    );

    // SPI engine side: accepts transfers and reports completion.
    modport slave (
        input  start, tx_data, ss_sel, cpol, cpha,
        output busy, done, rx_data
    );
endinterface

// File: rtl/spi_master_param.sv
// Parametrised full-duplex SPI master. One WIDTH-bit word per transfer, any of
// the four CPOL/CPHA modes chosen per transfer, selectable bit order, sclk
// half-period of CLK_DIV clk cycles, one of NUM_SS active-low slave selects.
// Sequence: IDLE -> SETUP (CLK_DIV cycles) -> SHIFT (2*WIDTH sclk edges)
// -> HOLD (CLK_DIV cycles) -> IDLE with a one-cycle done pulse.
module spi_master_param #(
    parameter int WIDTH     = 8,
    parameter int CLK_DIV   = 2,
    parameter int NUM_SS    = 2,
    parameter int SEL_W     = 1,
    parameter int MSB_FIRST = 1
) (
    input  logic                clk,
    input  logic                reset,
    spi_master_param_if.slave   ctrl,
    input  logic                miso,
    output logic                mosi,
    output logic                sclk,
    output logic [NUM_SS-1:0]   ss_n
);

    localparam int EDGES  = 2 * WIDTH;
    localparam int EDGE_W = $clog2(EDGES);
    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD
    } state_t;

    state_t              state;
    logic [DIV_W-1:0]    div_cnt;
    logic [EDGE_W-1:0]   edge_cnt;
    logic [WIDTH-1:0]    tx_sr;
    logic [WIDTH-1:0]    rx_sr;
    logic                cpha_l;
    logic [NUM_SS-1:0]   ss_dec;

    // One tick per sclk half-period while SETUP/SHIFT/HOLD are timing out.
    logic tick;
    logic last_edge;
    logic leading;

    assign tick      = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign last_edge = (edge_cnt == EDGE_W'(EDGES - 1));
    assign leading   = ~edge_cnt[0];

    // Slave-select decode of the requested index; an out-of-range index
    // leaves every line deasserted while the transfer still runs.
    generate
        for (genvar gi = 0; gi < NUM_SS; gi++) begin : g_ss_dec
            assign ss_dec[gi] = (ctrl.ss_sel != SEL_W'(gi));
        end
    endgenerate

    // Bit that goes out next, according to the configured bit order.
    function automatic logic out_bit(input logic [WIDTH-1:0] w);
        if (MSB_FIRST != 0)
            return w[WIDTH-1];
        else
            return w[0];
    endfunction

    // Drop the bit just presented so the next one moves into place.
    function automatic logic [WIDTH-1:0] shift_out(input logic [WIDTH-1:0] w);
        if (MSB_FIRST != 0)
            return {w[WIDTH-2:0], 1'b0};
        else
            return {1'b0, w[WIDTH-1:1]};
    endfunction

    // Append a received bit so the first bit ends up in the first-sent slot.
    function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] w,
                                                  input logic b);
        if (MSB_FIRST != 0)
            return {w[WIDTH-2:0], b};
        else
            return {b, w[WIDTH-1:1]};
    endfunction

    // Transfer sequencer: state, dividers, shift registers and all outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            div_cnt      <= '0;
            edge_cnt     <= '0;
            tx_sr        <= '0;
            rx_sr        <= '0;
            cpha_l       <= 1'b0;
            sclk         <= 1'b0;
            mosi         <= 1'b0;
            ss_n         <= '1;
            ctrl.busy    <= 1'b0;
            ctrl.done    <= 1'b0;
            ctrl.rx_data <= '0;
        end else begin
            ctrl.done <= 1'b0;
            case (state)
                IDLE: begin
                    // Track cpol continuously so the idle level is right
                    // before any slave select goes low.
                    sclk <= ctrl.cpol;
                    if (ctrl.start) begin
                        state     <= SETUP;
                        div_cnt   <= '0;
                        edge_cnt  <= '0;
                        cpha_l    <= ctrl.cpha;
                        ss_n      <= ss_dec;
                        ctrl.busy <= 1'b1;
                        if (!ctrl.cpha) begin
                            // CPHA=0 puts the first bit out before any edge.
                            mosi  <= out_bit(ctrl.tx_data);
                            tx_sr <= shift_out(ctrl.tx_data);
                        end else begin
                            tx_sr <= ctrl.tx_data;
                        end
                    end
                end

                SETUP, SHIFT: begin
                    if (tick) begin
                        div_cnt  <= '0;
                        sclk     <= ~sclk;
                        edge_cnt <= edge_cnt + 1'b1;
                        if (leading) begin
                            if (cpha_l) begin
                                mosi  <= out_bit(tx_sr);
                                tx_sr <= shift_out(tx_sr);
                            end else begin
                                rx_sr <= shift_in(rx_sr, miso);
                            end
                        end else begin
                            if (cpha_l) begin
                                rx_sr <= shift_in(rx_sr, miso);
                            end else if (!last_edge) begin
                                mosi  <= out_bit(tx_sr);
                                tx_sr <= shift_out(tx_sr);
                            end
                        end
                        state <= last_edge ? HOLD : SHIFT;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end

                HOLD: begin
                    if (tick) begin
                        div_cnt      <= '0;
                        state        <= IDLE;
                        ss_n         <= '1;
                        ctrl.busy    <= 1'b0;
                        ctrl.done    <= 1'b1;
                        ctrl.rx_data <= rx_sr;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_param.sv
// Directed bench for spi_master_param: default 8-bit MSB-first instance
// (CLK_DIV=2) plus a 16-bit LSB-first instance with CLK_DIV=1.
module tb_spi_master_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    int   checks   = 0;
    int   failures = 0;

    // Instance A: defaults
    spi_master_param_if #(.WIDTH(8), .SEL_W(1)) a_if ();
    logic       a_miso, a_mosi, a_sclk;
    logic [1:0] a_ss_n;

    spi_master_param #(
        .WIDTH(8), .CLK_DIV(2), .NUM_SS(2), .SEL_W(1), .MSB_FIRST(1)
    ) dut_a (
        .clk   (clk),
        .reset (reset),
        .ctrl  (a_if),
        .miso  (a_miso),
        .mosi  (a_mosi),
        .sclk  (a_sclk),
        .ss_n  (a_ss_n)
    );

    // Instance B: 16-bit, LSB first, fastest divider
    spi_master_param_if #(.WIDTH(16), .SEL_W(1)) b_if ();
    logic       b_miso, b_mosi, b_sclk;
    logic [1:0] b_ss_n;

    spi_master_param #(
        .WIDTH(16), .CLK_DIV(1), .NUM_SS(2), .SEL_W(1), .MSB_FIRST(0)
    ) dut_b (
        .clk   (clk),
        .reset (reset),
        .ctrl  (b_if),
        .miso  (b_miso),
        .mosi  (b_mosi),
        .sclk  (b_sclk),
        .ss_n  (b_ss_n)
    );

    logic       loopback;
    logic [7:0] slave_sr;

    assign a_miso = loopback ? a_mosi : slave_sr[7];
    assign b_miso = b_mosi;

    int a_done_cnt = 0;
    always @(negedge clk) if (a_if.done) a_done_cnt <= a_done_cnt + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // One transfer on A, observed once per cycle at the falling clk edge.
    // Cycle 1 is the first cycle after the edge that accepts start.
    task automatic run_a(input logic [7:0] tx, input logic sel, input logic pol,
                         input logic pha, input int poke_at,
                         output int t_ss, output int t_sclk, output int t_done,
                         output logic [1:0] ss_seen, output logic [7:0] mword,
                         output int mosi_bad);
        logic ps, pm, lead, trail;
        a_if.tx_data = tx;
        a_if.ss_sel  = sel;
        a_if.cpol    = pol;
        a_if.cpha    = pha;
        a_if.start   = 1'b1;
        t_ss = -1; t_sclk = -1; t_done = -1;
        ss_seen = 2'b11; mword = 8'h00; mosi_bad = 0;
        ps = a_sclk; pm = a_mosi;
        for (int i = 1; i <= 200 && t_done < 0; i++) begin
            @(negedge clk);
            if (i == 1) a_if.start = 1'b0;
            if (poke_at != 0 && i == poke_at) begin
                a_if.start   = 1'b1;
                a_if.tx_data = 8'h00;
                a_if.cpha    = ~pha;
            end
            if (poke_at != 0 && i == poke_at + 1) a_if.start = 1'b0;
            lead  = (ps == pol) && (a_sclk != pol);
            trail = (ps != pol) && (a_sclk == pol);
            if (t_ss < 0 && a_ss_n != 2'b11) begin
                t_ss    = i;
                ss_seen = a_ss_n;
            end
            if (t_sclk < 0 && a_sclk != pol) t_sclk = i;
            if (a_mosi != pm && !(pha ? lead : (trail || i == 1))) mosi_bad++;
            if (pha ? trail : lead) mword = {mword[6:0], a_mosi};
            if (trail && !loopback) slave_sr = {slave_sr[6:0], 1'b0};
            if (a_if.done) t_done = i;
            ps = a_sclk;
            pm = a_mosi;
        end
        $display("txn A tx=0x%02h sel=%0d mode=%0d rx=0x%02h mosi_word=0x%02h done_cyc=%0d",
                 tx, sel, {pol, pha}, a_if.rx_data, mword, t_done);
    endtask

    // One mode-1 transfer on B; mosi captured after each leading (rising) edge.
    task automatic run_b(input logic [15:0] tx, output int t_done, output logic [15:0] mword);
        logic ps;
        b_if.tx_data = tx;
        b_if.ss_sel  = 1'b0;
        b_if.cpol    = 1'b0;
        b_if.cpha    = 1'b1;
        b_if.start   = 1'b1;
        t_done = -1;
        mword  = 16'h0000;
        ps = b_sclk;
        for (int i = 1; i <= 200 && t_done < 0; i++) begin
            @(negedge clk);
            if (i == 1) b_if.start = 1'b0;
            if (!ps && b_sclk) mword = {b_mosi, mword[15:1]};
            if (b_if.done) t_done = i;
            ps = b_sclk;
        end
        $display("txn B tx=0x%04h rx=0x%04h mosi_word=0x%04h done_cyc=%0d",
                 tx, b_if.rx_data, mword, t_done);
    endtask

    int         t_ss, t_sclk, t_done, mosi_bad, cnt0, d1, d2, gap;
    logic [1:0] ss_seen;
    logic [7:0] mword, rx1, rx2;
    logic [15:0] bword;

    initial begin
        reset    = 1'b0;
        loopback = 1'b1;
        slave_sr = 8'h00;
        a_if.start = 1'b0; a_if.tx_data = '0; a_if.ss_sel = '0; a_if.cpol = 1'b0; a_if.cpha = 1'b0;
        b_if.start = 1'b0; b_if.tx_data = '0; b_if.ss_sel = '0; b_if.cpol = 1'b0; b_if.cpha = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ss_n", a_ss_n, 2'b11);
        check("rst_sclk", a_sclk, 1'b0);
        check("rst_mosi", a_mosi, 1'b0);
        check("rst_busy", a_if.busy, 1'b0);
        check("rst_done", a_if.done, 1'b0);
        check("rst_rx",   a_if.rx_data, 8'h00);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Mode 0, loopback, 0xA5
        run_a(8'hA5, 1'b0, 1'b0, 1'b0, 0, t_ss, t_sclk, t_done, ss_seen, mword, mosi_bad);
        check("m0_ss_cyc",   t_ss, 1);
        check("m0_ss_val",   ss_seen, 2'b10);
        check("m0_sclk_cyc", t_sclk, 3);
        check("m0_done_cyc", t_done, 35);
        check("m0_rx",       a_if.rx_data, 8'hA5);
        check("m0_ss_end",   a_ss_n, 2'b11);
        check("m0_busy_end", a_if.busy, 1'b0);
        check("m0_mosi",     mword, 8'hA5);
        check("m0_mosi_ph",  mosi_bad, 0);

        // Mode 3 against a slave returning 0xC3
        a_if.cpol = 1'b1;
        repeat (2) @(negedge clk);
        check("m3_sclk_idle", a_sclk, 1'b1);
        loopback = 1'b0;
        slave_sr = 8'hC3;
        run_a(8'h3C, 1'b1, 1'b1, 1'b1, 0, t_ss, t_sclk, t_done, ss_seen, mword, mosi_bad);
        check("m3_ss_val",   ss_seen, 2'b01);
        check("m3_rx",       a_if.rx_data, 8'hC3);
        check("m3_mosi",     mword, 8'h3C);
        check("m3_mosi_ph",  mosi_bad, 0);
        check("m3_done_cyc", t_done, 35);
        check("m3_sclk_end", a_sclk, 1'b1);
        loopback  = 1'b1;
        a_if.cpol = 1'b0;
        repeat (3) @(negedge clk);

        // Extra start pulse at cycle 10 is ignored
        cnt0 = a_done_cnt;
        run_a(8'h69, 1'b0, 1'b0, 1'b0, 10, t_ss, t_sclk, t_done, ss_seen, mword, mosi_bad);
        check("ign_done_cyc", t_done, 35);
        check("ign_rx",       a_if.rx_data, 8'h69);
        repeat (40) @(negedge clk);
        check("ign_one_done", a_done_cnt - cnt0, 1);

        // Reset at cycle 12 mid-transfer
        a_if.tx_data = 8'h77; a_if.ss_sel = 1'b0; a_if.cpha = 1'b0; a_if.cpol = 1'b0;
        a_if.start = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (i == 1) a_if.start = 1'b0;
        end
        check("mid_ss_pre", a_ss_n, 2'b10);
        reset = 1'b0;
        #1;
        check("mid_ss_n", a_ss_n, 2'b11);
        check("mid_sclk", a_sclk, 1'b0);
        check("mid_busy", a_if.busy, 1'b0);
        check("mid_rx",   a_if.rx_data, 8'h00);
        cnt0 = a_done_cnt;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (40) @(negedge clk);
        check("mid_no_done", a_done_cnt - cnt0, 0);
        run_a(8'h5A, 1'b0, 1'b0, 1'b0, 0, t_ss, t_sclk, t_done, ss_seen, mword, mosi_bad);
        check("post_rst_rx",   a_if.rx_data, 8'h5A);
        check("post_rst_done", t_done, 35);
        repeat (2) @(negedge clk);

        // Back-to-back with start held high
        a_if.tx_data = 8'h11; a_if.ss_sel = 1'b0; a_if.cpol = 1'b0; a_if.cpha = 1'b0;
        a_if.start = 1'b1;
        d1 = -1; d2 = -1; gap = 0; rx1 = 8'h00; rx2 = 8'h00;
        for (int i = 1; i <= 150 && d2 < 0; i++) begin
            @(negedge clk);
            if (a_if.done) begin
                if (d1 < 0) begin
                    d1 = i;
                    rx1 = a_if.rx_data;
                    a_if.tx_data = 8'h22;
                end else begin
                    d2 = i;
                    rx2 = a_if.rx_data;
                    a_if.start = 1'b0;
                end
            end
            if (d1 >= 0 && d2 < 0 && a_ss_n == 2'b11) gap++;
        end
        a_if.start = 1'b0;
        $display("txn A back-to-back rx1=0x%02h rx2=0x%02h done1=%0d done2=%0d gap=%0d",
                 rx1, rx2, d1, d2, gap);
        check("b2b_done1",   d1, 35);
        check("b2b_spacing", d2 - d1, 35);
        check("b2b_ss_gap",  gap, 1);
        check("b2b_rx1",     rx1, 8'h11);
        check("b2b_rx2",     rx2, 8'h22);

        // Instance B: 16-bit LSB-first, CLK_DIV=1, mode 1
        run_b(16'h0001, t_done, bword);
        check("b_done_cyc", t_done, 34);
        check("b_mosi_0001", bword, 16'h0001);
        check("b_rx_0001",  b_if.rx_data, 16'h0001);
        repeat (2) @(negedge clk);
        run_b(16'hB00D, t_done, bword);
        check("b_mosi_b00d", bword, 16'hB00D);
        check("b_rx_b00d",   b_if.rx_data, 16'hB00D);
        check("b_done_cyc2", t_done, 34);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
